hdmi_frame_ram_dp: RTL and testbench
====================================

# hdmi_frame_ram_dp

Parametrised dual-port on-chip frame memory for the HDMI display subsystem, replacing the fixed 32-bit × 77500 single-port RAM. Port s1 is an Avalon-MM read/write slave for the CPU/game-of-life engine. Port s2 is a read-only scan port for the pixel pipeline. A built-in clear engine fills the whole array with a constant, one word per cycle, on command.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 77500, number of words; need not be a power of 2.
- ADDR_W, 17, address width; must satisfy 2^ADDR_W ≥ DEPTH.
- INIT_FILE, "", hex init image; empty means no initialisation.
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- s1_address  in  ADDR_W  word address.
- s1_chipselect  in  1  slave select.
- s1_read  in  1  read request.
- s1_write  in  1  write request.
- s1_byteenable  in  DATA_W/8  per-byte write enables.
- s1_writedata  in  DATA_W  write data.
- s1_clken  in  1  s1 clock enable; when low, the s1 port freezes.
- s1_waitrequest  out  1  stall; high while the clear engine runs.
- s1_readdata  out  DATA_W  read data.
- s1_readdatavalid  out  1  s1_readdata valid this cycle.
- s2_address  in  ADDR_W  scan address.
- s2_read  in  1  scan read request.
- s2_readdata  out  DATA_W  scan data.
- s2_valid  out  1  s2_readdata valid this cycle.
- clear_start  in  1  one-cycle pulse to start a fill.
- clear_value  in  DATA_W  fill word; sampled on the accepted clear_start.
- clear_busy  out  1  fill in progress.
- clear_done  out  1  one-cycle pulse after the last fill write.

## Operation
- Memory is an inferred array of DEPTH×DATA_W. It is not reset; contents come from INIT_FILE or are undefined.
- s1 transfer accepted: s1_chipselect & (s1_read | s1_write) & !s1_waitrequest & s1_clken.
- s1 write: for each i with s1_byteenable[i]=1, update byte i; other bytes keep their value.
- s1_read and s1_write asserted together: the write wins and no read is issued.
- s1 and s2 are independent; both may act in the same cycle.
- Out-of-range address (≥ DEPTH):
  - Writes are dropped.
  - Reads complete normally but return 0.
- Read-during-write to the same address, on s1 or across s1/s2 in the same cycle: the read returns the old data.
- s1_clken low:
  - No s1 access is accepted.
  - The s1 read pipeline holds; s1_readdata and s1_readdatavalid keep their values.
- Clear FSM states:
  - IDLE → CLEAR on clear_start. Latch clear_value; counter=0.
  - CLEAR: write the latched value at the counter address with all bytes enabled; counter++.
  - At counter=DEPTH-1: perform the final write, pulse clear_done on the next cycle, return to IDLE.
  - clear_start during CLEAR is ignored.
- Writes go through one write mux: the clear engine has priority, and s1 is stalled by s1_waitrequest=clear_busy.
- s2 keeps serving during CLEAR and may return pre-fill or post-fill data.
- Reset mid-fill:
  - FSM returns to IDLE and the counter clears.
  - Memory keeps a partial fill; no clear_done pulse.

## Timing
- Reset values: s1_readdata=0, s1_readdatavalid=0, s1_waitrequest=0, s2_readdata=0, s2_valid=0, clear_busy=0, clear_done=0.
- s1 read latency: a read accepted in cycle N gives s1_readdatavalid=1 for exactly one enabled cycle at N+1. With HDMI_RAM_OUTREG_EN the latency is N+2.
- s2 read latency: s2_read in cycle N gives s2_valid=1 at N+1 (N+2 with the macro). s2 ignores s1_clken.
- Read pipeline: fully pipelined, one read per cycle on each port.
- clear_busy: rises the cycle after clear_start and stays high for exactly DEPTH cycles.
- clear_done: asserted in the cycle clear_busy falls.
- s1_waitrequest: equals clear_busy (combinational from the FSM register).

## Configuration
- HDMI_RAM_OUTREG_EN defined: an extra output register on both read ports. Latency is 2, for higher Fmax.
- HDMI_RAM_OUTREG_EN undefined: latency is 1, and readdata comes straight from the RAM output register.
- All other behaviour is identical in both builds.

## Structure
- Package hdmi_ram_pkg holds:
  - the clear-state enum (IDLE, CLEAR);
  - localparam RD_LATENCY, selected by the macro;
  - a function computing byte-lane count from DATA_W.
- Sub-module hdmi_ram_clear_fsm holds the FSM, counter and value latch. It outputs write enable, address, data and busy/done.
- The RAM array, write mux and read pipelines stay in the top module.

## Test plan
- Write with address 5, data 0xAABBCCDD, byteenable 4'b1111. Then write address 5, data 0x11223344, byteenable 4'b0101. Read 5 → 0xAA22CC44, with readdatavalid at N+1 (N+2 with the macro).
- Write address 77500, data 0xFFFFFFFF, then read 77500 → 0; address 77499 is unchanged.
- clear_start with value 0x0 while the array holds a pattern:
  - clear_busy is high for 77500 cycles and clear_done pulses once.
  - An s1 write issued mid-fill stalls under waitrequest and lands after the fill.
  - Read-back of 0, 40000 and 77499 → 0, then the stalled write's value at its own address.
- Same-cycle s1 write 0x5 and s2 read at address 10, which held 0x3 → s2_readdata=0x3; the next s2 read → 0x5.
- Assert reset at fill counter ≈1000:
  - All outputs are at their reset values.
  - No clear_done.
  - Address 0 → fill value; address 2000 → old data.
- Issue an s1 read, then drop s1_clken for 3 cycles → readdata and readdatavalid hold; no new access is accepted.

Source files
------------

// File: rtl/hdmi_ram_pkg.sv
// Shared types and constants for the HDMI dual-port frame RAM.
// RD_LATENCY follows the HDMI_RAM_OUTREG_EN build macro.
package hdmi_ram_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clear_state_t;

`ifdef HDMI_RAM_OUTREG_EN
   localparam int unsigned RD_LATENCY = 2;
`else
   localparam int unsigned RD_LATENCY = 1;
`endif

   function automatic int unsigned byte_lanes(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/hdmi_ram_clear_fsm.sv
// Clear engine for the HDMI frame RAM: sweeps every word once with a latched
// fill value, one word per cycle, then pulses done.
module hdmi_ram_clear_fsm
   import hdmi_ram_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 77500,
   parameter int unsigned ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] value,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   clear_state_t      state;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] fill;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         fill  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= CLEAR;
                  cnt   <= '0;
                  fill  <= value;
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               // start is deliberately not looked at here: a running fill cannot be retriggered
               if (cnt == LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt + ADDR_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign we   = busy;
   assign addr = cnt;
   assign data = fill;

endmodule

// File: rtl/hdmi_frame_ram_dp.sv
// Dual-port frame RAM: s1 Avalon-MM read/write slave, s2 read-only scan port,
// built-in clear engine. HDMI_RAM_OUTREG_EN adds an output register to both ports.
module hdmi_frame_ram_dp
  import hdmi_ram_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 77500,
  parameter int unsigned ADDR_W    = 17,
  parameter string       INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic                  s1_chipselect,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0]     s1_writedata,
  input  logic                  s1_clken,
  output logic                  s1_waitrequest,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  input  logic [ADDR_W-1:0]     s2_address,
  input  logic                  s2_read,
  output logic [DATA_W-1:0]     s2_readdata,
  output logic                  s2_valid,
  input  logic                  clear_start,
  input  logic [DATA_W-1:0]     clear_value,
  output logic                  clear_busy,
  output logic                  clear_done
);

  localparam int unsigned       BE_W    = byte_lanes(DATA_W);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_data;

  hdmi_ram_clear_fsm #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear (
    .clk   (clk),
    .rst   (reset),
    .start (clear_start),
    .value (clear_value),
    .we    (clr_we),
    .addr  (clr_addr),
    .data  (clr_data),
    .busy  (clear_busy),
    .done  (clear_done)
  );

  assign s1_waitrequest = clear_busy;

  logic s1_acc, s1_in_range, s2_in_range, s1_wr, s1_rd;

  assign s1_acc      = s1_chipselect & (s1_read | s1_write) & ~s1_waitrequest & s1_clken;
  assign s1_in_range = {1'b0, s1_address} < DEPTH_L;
  assign s2_in_range = {1'b0, s2_address} < DEPTH_L;
  assign s1_wr       = s1_acc & s1_write & s1_in_range;
  assign s1_rd       = s1_acc & s1_read & ~s1_write;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = s1_address;
    wr_data = s1_writedata;
    wr_be   = s1_byteenable;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = clr_data;
      wr_be   = '1;
    end else if (s1_wr) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (wr_be[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  // RAM output registers; reads see pre-write contents on an address collision
  logic [DATA_W-1:0] s1_q, s2_q;
  logic              s1_v, s2_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s1_v <= 1'b0;
    end else if (s1_clken) begin
      s1_v <= s1_rd;
      if (s1_rd) s1_q <= s1_in_range ? mem[s1_address] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_q <= '0;
      s2_v <= 1'b0;
    end else begin
      s2_v <= s2_read;
      if (s2_read) s2_q <= s2_in_range ? mem[s2_address] : '0;
    end
  end

`ifdef HDMI_RAM_OUTREG_EN
  logic [DATA_W-1:0] s1_q2, s2_q2;
  logic              s1_v2, s2_v2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q2 <= '0;
      s1_v2 <= 1'b0;
      s2_q2 <= '0;
      s2_v2 <= 1'b0;
    end else begin
      if (s1_clken) begin
        s1_q2 <= s1_q;
        s1_v2 <= s1_v;
      end
      s2_q2 <= s2_q;
      s2_v2 <= s2_v;
    end
  end

  assign s1_readdata      = s1_q2;
  assign s1_readdatavalid = s1_v2;
  assign s2_readdata      = s2_q2;
  assign s2_valid         = s2_v2;
`else
  assign s1_readdata      = s1_q;
  assign s1_readdatavalid = s1_v;
  assign s2_readdata      = s2_q;
  assign s2_valid         = s2_v;
`endif

endmodule

// File: tb/tb_hdmi_frame_ram_dp.sv
// Bench for hdmi_frame_ram_dp: word-level memory model checked every cycle,
// plus directed transactions with literal expected values.
`timescale 1ns/1ps
module tb_hdmi_frame_ram_dp;

   localparam int DW    = 32;
   localparam int DEPTH = 77500;
   localparam int AW    = 17;
`ifdef HDMI_RAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] s1_address;
   logic          s1_chipselect, s1_read, s1_write, s1_clken;
   logic [3:0]    s1_byteenable;
   logic [DW-1:0] s1_writedata;
   logic          s1_waitrequest;
   logic [DW-1:0] s1_readdata;
   logic          s1_readdatavalid;
   logic [AW-1:0] s2_address;
   logic          s2_read;
   logic [DW-1:0] s2_readdata;
   logic          s2_valid;
   logic          clear_start;
   logic [DW-1:0] clear_value;
   logic          clear_busy, clear_done;

   hdmi_frame_ram_dp #(
      .DATA_W    (DW),
      .DEPTH     (DEPTH),
      .ADDR_W    (AW),
      .INIT_FILE ("")
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .s1_address       (s1_address),
      .s1_chipselect    (s1_chipselect),
      .s1_read          (s1_read),
      .s1_write         (s1_write),
      .s1_byteenable    (s1_byteenable),
      .s1_writedata     (s1_writedata),
      .s1_clken         (s1_clken),
      .s1_waitrequest   (s1_waitrequest),
      .s1_readdata      (s1_readdata),
      .s1_readdatavalid (s1_readdatavalid),
      .s2_address       (s2_address),
      .s2_read          (s2_read),
      .s2_readdata      (s2_readdata),
      .s2_valid         (s2_valid),
      .clear_start      (clear_start),
      .clear_value      (clear_value),
      .clear_busy       (clear_busy),
      .clear_done       (clear_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] ref_mem [int];
   bit          p1_v [LAT];
   logic [31:0] p1_d [LAT];
   bit          p1_k [LAT];
   bit          p2_v [LAT];
   logic [31:0] p2_d [LAT];
   bit          p2_k [LAT];
   bit          m_busy, m_done;
   int          m_cnt;
   logic [31:0] m_val;

   task automatic m_reset();
      for (int i = 0; i < LAT; i++) begin
         p1_v[i] = 0; p1_d[i] = '0; p1_k[i] = 1;
         p2_v[i] = 0; p2_d[i] = '0; p2_k[i] = 1;
      end
      m_busy = 0; m_done = 0; m_cnt = 0; m_val = '0;
   endtask

   task automatic peek(input int a, output logic [31:0] v, output bit k);
      if (a >= DEPTH) begin v = '0; k = 1; end
      else if (ref_mem.exists(a)) begin v = ref_mem[a]; k = 1; end
      else begin v = '0; k = 0; end
   endtask

   task automatic m_step();
      bit          acc, rd1, wr1, k1, k2;
      logic [31:0] r1, r2, old;
      int          a1;
      a1  = int'(s1_address);
      acc = s1_chipselect && (s1_read || s1_write) && !m_busy && s1_clken;
      rd1 = acc && s1_read && !s1_write;
      wr1 = acc && s1_write;
      peek(a1, r1, k1);
      peek(int'(s2_address), r2, k2);
      if (m_busy) ref_mem[m_cnt] = m_val;
      else if (wr1 && a1 < DEPTH) begin
         old = ref_mem.exists(a1) ? ref_mem[a1] : '0;
         for (int b = 0; b < 4; b++)
            if (s1_byteenable[b]) old[b*8 +: 8] = s1_writedata[b*8 +: 8];
         ref_mem[a1] = old;
      end
      if (s1_clken) begin
         for (int i = LAT - 1; i > 0; i--) begin
            p1_v[i] = p1_v[i-1]; p1_d[i] = p1_d[i-1]; p1_k[i] = p1_k[i-1];
         end
         p1_v[0] = rd1; p1_d[0] = r1; p1_k[0] = k1;
      end
      for (int i = LAT - 1; i > 0; i--) begin
         p2_v[i] = p2_v[i-1]; p2_d[i] = p2_d[i-1]; p2_k[i] = p2_k[i-1];
      end
      p2_v[0] = s2_read; p2_d[0] = r2; p2_k[0] = k2;
      m_done = 0;
      if (m_busy) begin
         if (m_cnt == DEPTH - 1) begin m_busy = 0; m_done = 1; end
         else m_cnt++;
      end else if (clear_start) begin
         m_busy = 1; m_cnt = 0; m_val = clear_value;
      end
   endtask

   always @(negedge clk) begin
      if (reset) m_reset();
      check("s1_readdatavalid", {31'b0, s1_readdatavalid}, {31'b0, p1_v[LAT-1]});
      if (p1_v[LAT-1] && p1_k[LAT-1]) check("s1_readdata", s1_readdata, p1_d[LAT-1]);
      check("s2_valid", {31'b0, s2_valid}, {31'b0, p2_v[LAT-1]});
      if (p2_v[LAT-1] && p2_k[LAT-1]) check("s2_readdata", s2_readdata, p2_d[LAT-1]);
      check("clear_busy", {31'b0, clear_busy}, {31'b0, m_busy});
      check("s1_waitrequest", {31'b0, s1_waitrequest}, {31'b0, m_busy});
      check("clear_done", {31'b0, clear_done}, {31'b0, m_done});
      if (!reset) m_step();
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic s1_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
      s1_chipselect = 1; s1_write = 1; s1_address = a; s1_writedata = d; s1_byteenable = be;
      tick();
      s1_chipselect = 0; s1_write = 0;
   endtask

   task automatic s1_rd_lit(input logic [AW-1:0] a, input logic [31:0] exp, input string nm);
      s1_chipselect = 1; s1_read = 1; s1_address = a;
      tick();
      s1_chipselect = 0; s1_read = 0;
      repeat (LAT - 1) tick();
      check({nm, "_valid"}, {31'b0, s1_readdatavalid}, 32'd1);
      check(nm, s1_readdata, exp);
   endtask

   task automatic s2_rd_lit(input logic [AW-1:0] a, input logic [31:0] exp, input string nm);
      s2_read = 1; s2_address = a;
      tick();
      s2_read = 0;
      repeat (LAT - 1) tick();
      check({nm, "_valid"}, {31'b0, s2_valid}, 32'd1);
      check(nm, s2_readdata, exp);
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, "_s1_readdata"}, s1_readdata, 32'h0);
      check({nm, "_s1_readdatavalid"}, {31'b0, s1_readdatavalid}, 32'h0);
      check({nm, "_s1_waitrequest"}, {31'b0, s1_waitrequest}, 32'h0);
      check({nm, "_s2_readdata"}, s2_readdata, 32'h0);
      check({nm, "_s2_valid"}, {31'b0, s2_valid}, 32'h0);
      check({nm, "_clear_busy"}, {31'b0, clear_busy}, 32'h0);
      check({nm, "_clear_done"}, {31'b0, clear_done}, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cycles, done_cnt;
      bit pending, free;

      reset = 1; s1_address = '0; s1_chipselect = 0; s1_read = 0; s1_write = 0;
      s1_byteenable = '0; s1_writedata = '0; s1_clken = 1; s2_address = '0; s2_read = 0;
      clear_start = 0; clear_value = '0;
      repeat (3) tick();
      check_reset_outputs("reset");
      reset = 0;
      tick();

      // byte-enable merge
      s1_wr(17'd5, 32'hAABBCCDD, 4'b1111);
      s1_wr(17'd5, 32'h11223344, 4'b0101);
      s1_rd_lit(17'd5, 32'hAA22CC44, "byteen_merge");

      // out-of-range write dropped, read returns zero
      s1_wr(17'd77499, 32'h12345678, 4'hF);
      s1_wr(17'd77500, 32'hFFFFFFFF, 4'hF);
      s1_rd_lit(17'd77500, 32'h0, "oor_read");
      s1_rd_lit(17'd77499, 32'h12345678, "last_word_intact");

      // s1 write and s2 read of the same word in one cycle
      s1_wr(17'd10, 32'h3, 4'hF);
      s1_chipselect = 1; s1_write = 1; s1_address = 17'd10; s1_writedata = 32'h5; s1_byteenable = 4'hF;
      s2_read = 1; s2_address = 17'd10;
      tick();
      s1_chipselect = 0; s1_write = 0; s2_read = 0;
      repeat (LAT - 1) tick();
      check("rdw_old_data", s2_readdata, 32'h3);
      s2_rd_lit(17'd10, 32'h5, "rdw_new_data");

      // s1_clken hold: valid/data freeze, a write during the freeze is ignored
      s1_chipselect = 1; s1_read = 1; s1_address = 17'd5;
      tick();
      s1_chipselect = 0; s1_read = 0;
      repeat (LAT - 1) tick();
      s1_clken = 0; s1_chipselect = 1; s1_write = 1; s1_address = 17'd5;
      s1_writedata = 32'h0; s1_byteenable = 4'hF;
      repeat (3) begin
         tick();
         check("hold_valid", {31'b0, s1_readdatavalid}, 32'd1);
         check("hold_data", s1_readdata, 32'hAA22CC44);
      end
      s1_chipselect = 0; s1_write = 0; s1_clken = 1;
      tick();
      check("release_valid", {31'b0, s1_readdatavalid}, 32'd0);
      s1_rd_lit(17'd5, 32'hAA22CC44, "write_blocked_by_clken");

      // full clear with a stalled write and an ignored restart
      s1_wr(17'd0, 32'hDEAD0000, 4'hF);
      s1_wr(17'd40000, 32'h00040000, 4'hF);
      clear_value = 32'h0; clear_start = 1;
      tick();
      clear_start = 0; clear_value = 32'hFFFFFFFF;
      busy_cycles = clear_busy ? 1 : 0;
      done_cnt = clear_done ? 1 : 0;
      pending = 0;
      for (int c = 0; c < DEPTH + 50; c++) begin
         if (c == 100) begin
            s1_chipselect = 1; s1_write = 1; s1_address = 17'd300;
            s1_writedata = 32'hCAFEF00D; s1_byteenable = 4'hF; pending = 1;
         end
         if (c == 200) clear_start = 1;
         free = !s1_waitrequest;
         tick();
         clear_start = 0;
         if (pending && free) begin
            s1_chipselect = 0; s1_write = 0; pending = 0;
         end
         if (clear_busy) busy_cycles++;
         if (clear_done) done_cnt++;
         if (!pending && !clear_busy && c > 200) break;
      end
      check("clear_busy_cycles", busy_cycles, DEPTH);
      check("clear_done_pulses", done_cnt, 32'd1);
      check("stalled_write_accepted", {31'b0, pending}, 32'd0);
      s1_chipselect = 0; s1_write = 0;
      s1_rd_lit(17'd0, 32'h0, "clear_addr0");
      s1_rd_lit(17'd40000, 32'h0, "clear_addr40000");
      s1_rd_lit(17'd77499, 32'h0, "clear_addr77499");
      s1_rd_lit(17'd300, 32'hCAFEF00D, "stalled_write_landed");

      // reset in the middle of a fill
      s1_wr(17'd2000, 32'h00002000, 4'hF);
      s1_rd_lit(17'd2000, 32'h00002000, "pre_fill_2000");
      clear_value = 32'h5A5A5A5A; clear_start = 1;
      tick();
      clear_start = 0;
      repeat (1000) tick();
      reset = 1;
      #1;
      check_reset_outputs("midfill_reset");
      tick();
      tick();
      reset = 0;
      done_cnt = 0;
      repeat (5) begin
         tick();
         if (clear_done) done_cnt++;
      end
      check("no_done_after_reset", done_cnt, 32'd0);
      s1_rd_lit(17'd0, 32'h5A5A5A5A, "partial_fill_addr0");
      s1_rd_lit(17'd2000, 32'h00002000, "partial_fill_addr2000");
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
